// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine: MULT, MULTU, DIV, DIVU, one bit per cycle.
// Produces a {HI,LO} result with a one-cycle done pulse after WIDTH iterations.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);
    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | iterating, one operand bit per cycle
    // S_DONE | result valid for this cycle, start may relaunch
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_launch;
    logic                 w_last;

    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_opa_raw;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_bz;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_signed;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_quo;
    logic [2*WIDTH-1:0]   w_final;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed && opa[WIDTH-1]) ? -opa : opa;
    assign w_abs_b  = (w_signed && opb[WIDTH-1]) ? -opb : opb;

    // Multiply: the 65-bit accumulator's top bit is always zero after the shift,
    // so the carry of the add lands directly in bit 2*WIDTH-1 of the stored value.
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
    assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_m};

    always_comb begin
        w_acc_nxt = r_acc;
        if (r_is_div) begin
            if (!w_diff[WIDTH]) w_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else                w_acc_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            if (r_acc[0]) w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
            else          w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    assign w_rem = w_acc_nxt[2*WIDTH-1:WIDTH];
    assign w_quo = w_acc_nxt[WIDTH-1:0];

    always_comb begin
        w_final = w_acc_nxt;
        if (!r_is_div) begin
            if (r_neg_q) w_final = -w_acc_nxt;
        end else if (r_bz) begin
            w_final = {r_opa_raw, {WIDTH{1'b1}}};
        end else begin
            w_final[2*WIDTH-1:WIDTH] = r_neg_r ? -w_rem : w_rem;
            w_final[WIDTH-1:0]       = r_neg_q ? -w_quo : w_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_m       <= '0;
            r_opa_raw <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_bz      <= 1'b0;
            r_result  <= '0;
        end else if (w_launch) begin
            r_cnt     <= '0;
            r_is_div  <= op[1];
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            r_m       <= op[1] ? w_abs_b : w_abs_a;
            r_opa_raw <= opa;
            r_neg_q   <= w_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            r_neg_r   <= w_signed & opa[WIDTH-1];
            r_bz      <= (opb == '0);
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_result <= w_final;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, back-to-back launch and mid-run reset.
module tb_mult_div_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drives start for one edge; returns #1 after the launch edge
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        step();
        start = 1'b0;
    endtask

    // n counts edges from the launch edge to the edge that raises done
    task automatic wait_done(input int n0, output int n, output int nb);
        n  = n0;
        nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        opa   = '0;
        opb   = '0;
        repeat (3) step();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_cmp++;
        if (result !== 64'h0) begin n_err++; $display("FAIL reset_result got %h exp 0", result); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_multu_latency();
        int n, nb;
        logic [63:0] held;
        launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, n, nb);
        n_cmp++;
        if (n !== 33) begin n_err++; $display("FAIL multu_latency got %0d exp 33", n); end
        n_cmp++;
        if (nb !== 32) begin n_err++; $display("FAIL multu_busy_cycles got %0d exp 32", nb); end
        n_cmp++;
        if (result !== 64'hFFFF_FFFE_0000_0001) begin
            n_err++; $display("FAIL multu_result got %h exp fffffffe00000001", result);
        end
        held = 64'hFFFF_FFFE_0000_0001;
        step();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL done_pulse got done=%b busy=%b exp 0 0", done, busy);
        end
        step();
        n_cmp++;
        if (result !== held) begin n_err++; $display("FAIL result_hold got %h exp %h", result, held); end
    endtask

    task automatic test_mult_signed();
        int n, nb;
        launch(MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done(1, n, nb);
        n_cmp++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_err++; $display("FAIL mult_neg3x7 got %h exp ffffffffffffffeb", result);
        end
        step();
        launch(MULT, 32'h0000_0000, 32'h1234_5678);
        wait_done(1, n, nb);
        n_cmp++;
        if (result !== 64'h0) begin n_err++; $display("FAIL mult_zero got %h exp 0", result); end
        step();
    endtask

    task automatic test_div();
        int n, nb;
        launch(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(1, n, nb);
        n_cmp++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_err++; $display("FAIL div_neg7by2 got %h exp fffffffffffffffd", result);
        end
        step();
        launch(DIVU, 32'h0000_0007, 32'h0000_0002);
        wait_done(1, n, nb);
        n_cmp++;
        if (result !== 64'h0000_0001_0000_0003) begin
            n_err++; $display("FAIL divu_7by2 got %h exp 0000000100000003", result);
        end
        step();
    endtask

    task automatic test_div_corner();
        int n, nb;
        launch(DIVU, 32'h0000_0064, 32'h0000_0000);
        wait_done(1, n, nb);
        n_cmp++;
        if (n !== 33) begin n_err++; $display("FAIL divzero_latency got %0d exp 33", n); end
        n_cmp++;
        if (result !== 64'h0000_0064_FFFF_FFFF) begin
            n_err++; $display("FAIL divzero got %h exp 00000064ffffffff", result);
        end
        step();
        launch(DIV, 32'hFFFF_FFF9, 32'h0000_0000);
        wait_done(1, n, nb);
        n_cmp++;
        if (result !== 64'hFFFF_FFF9_FFFF_FFFF) begin
            n_err++; $display("FAIL div_signed_zero got %h exp fffffff9ffffffff", result);
        end
        step();
        launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, n, nb);
        n_cmp++;
        if (result !== 64'h0000_0000_8000_0000) begin
            n_err++; $display("FAIL div_overflow got %h exp 0000000080000000", result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n, nb;
        launch(MULTU, 32'h0000_0005, 32'h0000_0006);
        n = 1;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            op    = DIVU;
            opa   = 32'h0000_0100;
            opb   = 32'h0000_0007;
            step();
            n++;
        end
        start = 1'b0;
        wait_done(n, n, nb);
        n_cmp++;
        if (n !== 33) begin n_err++; $display("FAIL ignore_start_latency got %0d exp 33", n); end
        n_cmp++;
        if (result !== 64'h0000_0000_0000_001E) begin
            n_err++; $display("FAIL b2b_first got %h exp 000000000000001e", result);
        end
        launch(DIVU, 32'h0000_0009, 32'h0000_0004);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_no_bubble got busy=%b exp 1", busy); end
        wait_done(1, n, nb);
        n_cmp++;
        if (n !== 33) begin n_err++; $display("FAIL b2b_latency got %0d exp 33", n); end
        n_cmp++;
        if (result !== 64'h0000_0001_0000_0002) begin
            n_err++; $display("FAIL b2b_second got %h exp 0000000100000002", result);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int n, nb;
        launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrun_reset_flags got busy=%b done=%b exp 0 0", busy, done);
        end
        n_cmp++;
        if (result !== 64'h0) begin n_err++; $display("FAIL midrun_reset_result got %h exp 0", result); end
        repeat (30) step();
        n_cmp++;
        if (done !== 1'b0 || result !== 64'h0) begin
            n_err++; $display("FAIL midrun_no_completion got done=%b result=%h exp 0 0", done, result);
        end
        launch(MULTU, 32'h0000_0003, 32'h0000_0003);
        wait_done(1, n, nb);
        n_cmp++;
        if (n !== 33) begin n_err++; $display("FAIL after_reset_latency got %0d exp 33", n); end
        n_cmp++;
        if (result !== 64'h9) begin n_err++; $display("FAIL after_reset_result got %h exp 9", result); end
        step();
    endtask

    initial begin
        test_reset();
        test_multu_latency();
        test_mult_signed();
        test_div();
        test_div_corner();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
